// File: rtl/uart_tx_fifo.sv
// UART transmitter with a one-word holding register; TX falls one edge after acceptance and frames run back-to-back.
// READY drops while a word is held and stays low during RST; SEND without READY is ignored.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SEND,
  input  logic [DATA_BITS-1:0] DATA,
  output logic                 READY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TX
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {sIdle, sStart, sData, sParity, sStop} state_t;

  state_t               state;
  logic                 holdValid;
  logic [DATA_BITS-1:0] holdData;
  logic [DATA_BITS-1:0] shiftReg;
  logic [TW-1:0]        bitTimer;
  logic [IW-1:0]        bitIdx;
  logic                 stopIdx;
  logic                 parityBit;
  logic                 bitDone;
  logic                 lastStop;
  logic                 accept;
  logic                 loadNow;

  assign READY    = ~holdValid & ~RST;
  assign BUSY     = holdValid | (state != sIdle);
  assign accept   = SEND & READY;
  assign bitDone  = (bitTimer == LAST_TICK);
  assign lastStop = (STOP_BITS == 1) || stopIdx;
  // The held word moves into the shifter either from idle or straight off the final stop bit.
  assign loadNow  = holdValid & ((state == sIdle) | ((state == sStop) & bitDone & lastStop));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= sIdle;
      TX        <= 1'b1;
      DONE      <= 1'b0;
      holdValid <= 1'b0;
      holdData  <= '0;
      shiftReg  <= '0;
      bitTimer  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      parityBit <= 1'b0;
    end else begin
      DONE <= 1'b0;

      if (accept) begin
        holdData  <= DATA;
        holdValid <= 1'b1;
      end else if (loadNow) begin
        holdValid <= 1'b0;
      end

      if (state != sIdle)
        bitTimer <= bitDone ? '0 : bitTimer + 1'b1;

      case (state)
        sIdle: begin
          if (holdValid) begin
            TX    <= 1'b0;
            state <= sStart;
          end
        end
        sStart: begin
          if (bitDone) begin
            TX       <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
            state    <= sData;
          end
        end
        sData: begin
          if (bitDone) begin
            if (bitIdx == LAST_BIT) begin
              stopIdx <= 1'b0;
              if (PARITY_EN != 0) begin
                TX    <= parityBit;
                state <= sParity;
              end else begin
                TX    <= 1'b1;
                state <= sStop;
              end
            end else begin
              TX       <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitIdx   <= bitIdx + 1'b1;
            end
          end
        end
        sParity: begin
          if (bitDone) begin
            TX      <= 1'b1;
            stopIdx <= 1'b0;
            state   <= sStop;
          end
        end
        sStop: begin
          if (bitDone) begin
            if (lastStop) begin
              DONE <= 1'b1;
              if (holdValid) begin
                TX    <= 1'b0;
                state <= sStart;
              end else begin
                state <= sIdle;
              end
            end else begin
              stopIdx <= stopIdx + 1'b1;
            end
          end
        end
        default: begin
          TX    <= 1'b1;
          state <= sIdle;
        end
      endcase

      // Parity comes from the stored word so later DATA changes cannot leak into the frame.
      if (loadNow) begin
        shiftReg  <= holdData;
        parityBit <= (^holdData) ^ (PARITY_ODD != 0);
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 / 9600-baud / 100 MHz transmitter.
- Adds configurable bit period, data width, optional parity and 1 or 2 stop bits.
- Adds a one-entry holding register so frames go out back-to-back with no idle gap.
- Adds a frame-done pulse and a proper valid/ready handshake; DATA is latched only on acceptance.
- Sits between the processor's I/O register block and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600); legal range >= 2.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- CLK  in  1  system clock; one clock domain only.
- RST  in  1  reset, synchronous, active-high.
- SEND  in  1  request to send DATA; accepted on a rising CLK edge where SEND=1 and READY=1.
- DATA  in  DATA_BITS  byte/word to transmit; sampled only on acceptance.
- READY  out  1  holding register empty; a new word can be accepted.
- BUSY  out  1  frame in progress or holding register full.
- DONE  out  1  one-cycle pulse at the end of each frame's last stop bit.
- TX  out  1  serial line; idle high; registered output.

Behaviour:
- Reset (RST=1 at an edge):
  - TX=1, DONE=0, state IDLE.
  - Holding register cleared; bit timer and bit index cleared.
  - READY is forced 0 combinationally while RST=1; READY=1 on the first cycle after RST falls.
  - Reset mid-frame aborts the frame: TX=1 from the next edge, and the queued word is discarded.
  - RST has priority over SEND in the same cycle.
- Accept:
  - On the edge with SEND & READY: hold <= DATA, hold_valid <= 1.
  - SEND while READY=0 is ignored and DATA is not sampled.
  - READY = ~hold_valid & ~RST.
  - BUSY = hold_valid | (state != IDLE).
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE & hold_valid: at the next edge, the shift register loads from hold, hold_valid <= 0, TX <= 0, state <= START.
    - TX therefore falls one edge after acceptance.
    - A new word can be accepted in the cycle after the transfer.
  - Every state holds TX for exactly CLKS_PER_BIT cycles.
    - The bit timer counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
    - bit_done = (timer == CLKS_PER_BIT-1).
  - START --bit_done--> DATA, TX <= shift[0].
  - DATA: on each bit_done, shift right and increment the index.
    - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: TX = XOR of the frame's data bits XOR PARITY_ODD. Computed at load time from the stored word, not from the live DATA port. Then go to STOP.
  - STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - On the final bit_done, DONE=1 for exactly that one following cycle.
    - If hold_valid=1 at that edge: load the next word, TX <= 0, state START, with zero idle cycles between frames.
    - Otherwise: state IDLE, TX stays 1.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, exactly.
- DONE and an acceptance in the same cycle are independent and both take effect.
- Unreachable state encodings return to IDLE with TX=1.

Test Plan:
- Reset: CLKS_PER_BIT=4, 8N1, RST held 3 cycles -> TX=1, READY=0 during reset, READY=1 and BUSY=0 after release, DONE never pulses.
- Single frame: SEND 0xA5 for one cycle -> TX falls one edge later. Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). DONE pulses once at the end. READY is high again one cycle after acceptance.
- Back-to-back: accept 0x3C, then 0xC3 while the first is in flight -> second start bit immediately follows the first stop bit with no gap. A third SEND while READY=0 is ignored: only two frames are sent and the third DATA is never transmitted.
- Parity/stop: PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, data 0xA5 -> parity bit 1, then two stop bits, 48 cycles total. With PARITY_ODD=0 -> parity bit 0.
- Width: DATA_BITS=7, data 0x41 -> 9 bits of frame = start, 1,0,0,0,0,0,1, stop. Upper input bits are ignored.
- Reset mid-frame: assert RST during data bit 3 with one word queued -> TX=1 from the next edge, no DONE, and the queued word is never sent. A fresh SEND after release produces a clean full frame.
